dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH, default 4096: number of 12-bit data-memory words; legal range 2..4096.
REQ-002 Parameter DUMP_LEN, default 4096: words streamed out after program end, from address 0; must be <= DEPTH.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ar_in  input  12  processor address register (data-memory address).
REQ-006 dm_en  input  1  processor data-memory write enable.
REQ-007 wr_data  input  17  processor bus value; bits [11:0] are the write data, bits [16:12] are ignored.
REQ-008 dm_out  output  12  registered read data returned to the processor.
REQ-009 end_process  input  1  processor program-complete flag.
REQ-010 proc_start  output  1  high while the processor may run (RUN state).
REQ-011 ld_valid / ld_data[11:0] / ld_last  input  1/12/1  host preload stream.
REQ-012 ld_ready  output  1  preload handshake ready.
REQ-013 dump_valid / dump_data[11:0] / dump_last  output  1/12/1  result dump stream.
REQ-014 dump_ready  input  1  dump handshake ready.
REQ-015 done  output  1  high in DONE state.

Function
REQ-016 FSM states: LOAD, RUN, DUMP, DONE; reset enters LOAD.
REQ-017 LOAD: ld_ready=1; each cycle with ld_valid&ld_ready writes ld_data to mem[ld_ptr] and increments ld_ptr.
REQ-018 LOAD->RUN after the accepted word carrying ld_last, or after the word written at ld_ptr=DEPTH-1, whichever comes first.
REQ-019 RUN: proc_start=1; read latency is exactly 1 cycle: dm_out at edge N+1 = mem[ar_in sampled at edge N].
REQ-020 RUN: dm_en=1 at an edge writes wr_data[11:0] to mem[ar_in].
REQ-021 Same-edge read and write to one address return the old data on dm_out (read-before-write).
REQ-022 ar_in >= DEPTH: reads return 0, writes are discarded.
REQ-023 RUN->DUMP on the first edge sampling end_process=1; a dm_en write sampled on that same edge is still performed.
REQ-024 dm_en outside RUN is ignored; ld_valid outside LOAD is ignored (ld_ready=0).
REQ-025 DUMP: the word at dump_ptr is fetched, then presented with dump_valid=1 one cycle later; dump_data and dump_last stay stable while dump_valid&!dump_ready.
REQ-026 On a dump handshake, dump_ptr increments, dump_valid drops for exactly one fetch cycle, then the next word is presented (max throughput 1 word / 2 cycles).
REQ-027 dump_last=1 only with the word at address DUMP_LEN-1; its handshake moves the FSM to DONE.
REQ-028 DONE: done=1, proc_start=0, ld_ready=0, dump_valid=0; the FSM remains in DONE until reset.
REQ-029 dm_out holds its last value outside RUN.

Reset
REQ-030 rst_n low asynchronously forces state=LOAD, ld_ptr=0, dump_ptr=0, dm_out=0, proc_start=0, dump_valid=0, dump_last=0, dump_data=0, done=0; ld_ready=1 after release.
REQ-031 Memory contents are not cleared by reset; reset during any state, including mid-handshake, aborts that operation with no partial-word side effects after assertion.
REQ-032 Release is synchronised internally (two-flop) before the FSM leaves reset behaviour.

Structure
REQ-033 Shared package dm_pkg holds the state enum, ADDR_W=12, DATA_W=12, and BUS_W=17.
REQ-034 Sub-module dm_ram: single-port synchronous RAM (one read/write port, registered output, read-before-write), BRAM-inferable; the FSM muxes address and write data by state.

Verification
REQ-035 Preload 3 words 0x00A, 0x00B, 0x00C (ld_last on 3rd) -> ld_ready drops and proc_start=1 the cycle after the 3rd handshake.
REQ-036 RUN, ar_in=2, no write -> dm_out=0x00C one cycle later; ar_in=2, dm_en=1, wr_data=0x1F123 -> dm_out=0x00C, then 0x123 on the next read.
REQ-037 DEPTH=16, ar_in=20 with dm_en=1, wr_data=0x7FF -> write discarded; read of address 20 returns 0; mem[4] unchanged.
REQ-038 DUMP_LEN=3, end_process=1, dump_ready toggling 1/0 -> words 0x00A, 0x00B, 0x123 in order, stable while stalled, dump_last only on 0x123, then done=1.
REQ-039 rst_n pulsed low mid-DUMP (after 1 word) -> outputs reset values immediately; state LOAD; memory still holds 0x00A at address 0 on reload-free RUN (ld_last on first word).

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and widths for the data-memory responder: FSM state encoding and bus widths.
package dm_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int BUS_W  = 17;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } dm_state_e;
endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous RAM with registered read-before-write output; no reset so it maps to block RAM.
module dm_ram
  import dm_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: host preload, processor read/write service while running, then a paced dump of results.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH    = 4096,
  parameter int DUMP_LEN = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic              dm_en,
  input  logic [BUS_W-1:0]  wr_data,
  output logic [DATA_W-1:0] dm_out,
  input  logic              end_process,
  output logic              proc_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1    = ADDR_W + 1;
  localparam logic [AW1-1:0]    DEPTH_LIM = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LD_TOP    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DUMP_TOP  = ADDR_W'(DUMP_LEN - 1);

  localparam logic [1:0] S_LOAD = 2'(ST_LOAD);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_DUMP = 2'(ST_DUMP);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  // Reset asserts asynchronously through both flops; release reaches the FSM two edges later.
  logic [1:0] rst_sync;
  logic       active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign active = rst_sync[1];

  logic [1:0]        state;
  logic [ADDR_W-1:0] ld_ptr;
  logic [ADDR_W-1:0] dump_ptr;
  logic              dump_valid_q;
  logic              rd_valid_q;
  logic              oor_q;
  logic [DATA_W-1:0] dm_hold_q;

  logic              addr_ok;
  logic              ld_end;
  logic              dump_end;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_bits;

  assign addr_ok     = {1'b0, ar_in} < DEPTH_LIM;
  assign ld_end      = ld_last || (ld_ptr == LD_TOP);
  assign dump_end    = (dump_ptr == DUMP_TOP);
  assign unused_bits = ^wr_data[BUS_W-1:DATA_W];

  // The single RAM port belongs to whichever phase is active.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      S_LOAD: begin
        ram_we    = ld_valid;
        ram_addr  = ld_ptr[RAM_AW-1:0];
        ram_wdata = ld_data;
      end
      S_RUN: begin
        ram_we    = dm_en && addr_ok;
        ram_addr  = ar_in[RAM_AW-1:0];
        ram_wdata = wr_data[DATA_W-1:0];
      end
      S_DUMP: begin
        ram_addr  = dump_ptr[RAM_AW-1:0];
      end
      default: ;
    endcase
  end

  dm_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && active),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Handshakes (ld_*, dump_*): a word transfers on any posedge where valid && ready are both high;
  // the producer keeps data and last stable while valid && !ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LOAD;
      ld_ptr       <= '0;
      dump_ptr     <= '0;
      dump_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      oor_q        <= 1'b0;
      dm_hold_q    <= '0;
    end else if (!active) begin
      state        <= S_LOAD;
      ld_ptr       <= '0;
      dump_ptr     <= '0;
      dump_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      oor_q        <= 1'b0;
      dm_hold_q    <= '0;
    end else begin
      rd_valid_q <= (state == S_RUN);
      oor_q      <= !addr_ok;
      dm_hold_q  <= dm_out;
      case (state)
        S_LOAD: begin
          if (ld_valid) begin
            ld_ptr <= ld_ptr + 12'd1;
            if (ld_end) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (end_process) begin
            state        <= S_DUMP;
            dump_ptr     <= '0;
            dump_valid_q <= 1'b0;
          end
        end
        S_DUMP: begin
          // A cycle with dump_valid low is the fetch cycle for the word at dump_ptr.
          if (!dump_valid_q) begin
            dump_valid_q <= 1'b1;
          end else if (dump_ready) begin
            dump_valid_q <= 1'b0;
            if (dump_end) state <= S_DONE;
            else          dump_ptr <= dump_ptr + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dm_out     = rd_valid_q ? (oor_q ? '0 : ram_rdata) : dm_hold_q;
  assign ld_ready   = (state == S_LOAD) && active;
  assign proc_start = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_valid_q ? ram_rdata : '0;
  assign dump_last  = dump_valid_q && dump_end;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: preload, randomized RUN traffic against a memory model, paced dump and reset aborts.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int DEPTH    = 16;
  localparam int DUMP_LEN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] ar_in = '0;
  logic        dm_en = 1'b0;
  logic [16:0] wr_data = '0;
  logic [11:0] dm_out;
  logic        end_process = 1'b0;
  logic        proc_start;
  logic        ld_valid = 1'b0;
  logic [11:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        dump_valid;
  logic [11:0] dump_data;
  logic        dump_last;
  logic        dump_ready = 1'b0;
  logic        done;
  logic [1:0]  dbg_state;

  dm_responder #(.DEPTH(DEPTH), .DUMP_LEN(DUMP_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .ar_in(ar_in), .dm_en(dm_en), .wr_data(wr_data),
    .dm_out(dm_out), .end_process(end_process), .proc_start(proc_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
    .dump_ready(dump_ready), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] model_mem [DEPTH];
  int          ld_ptr_m = 0;
  logic [11:0] exp_rd_q [$];
  logic [12:0] exp_dump_q [$];
  logic [11:0] last_rd_exp = '0;
  logic        mon_en = 1'b0;
  logic        rd_tag = 1'b0;
  logic        rd_pending = 1'b0;
  int          n_dump_hs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_read(input logic [11:0] a);
    if (int'(a) < DEPTH) return model_mem[int'(a)];
    return 12'h000;
  endfunction

  // read monitor: a read sampled at a posedge is visible on dm_out by the following negedge
  always @(posedge clk) rd_pending <= rd_tag;

  always @(negedge clk) begin
    if (mon_en && rd_pending) begin
      if (exp_rd_q.size() == 0) check("rd_queue_underflow", 32'(exp_rd_q.size()), 1);
      else check("dm_out", {20'h0, dm_out}, {20'h0, exp_rd_q.pop_front()});
    end
  end

  // dump monitor: word order/content, stability under stall, one-cycle gap after each handshake
  logic        stall_prev = 1'b0;
  logic [12:0] prev_word = '0;
  int          gap = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
      gap = 0;
    end else begin
      if (gap == 1) begin
        check("dump_gap", {31'h0, dump_valid}, 0);
        gap = prev_word[12] ? 0 : 2;
      end else if (gap == 2) begin
        check("dump_next", {31'h0, dump_valid}, 1);
        gap = 0;
      end
      if (dump_valid) begin
        if (stall_prev) check("dump_stable", {19'h0, dump_last, dump_data}, {19'h0, prev_word});
        prev_word = {dump_last, dump_data};
        if (dump_ready) begin
          if (exp_dump_q.size() == 0) check("dump_extra_word", 32'(exp_dump_q.size()), 1);
          else check("dump_word", {19'h0, dump_last, dump_data}, {19'h0, exp_dump_q.pop_front()});
          n_dump_hs++;
          gap = 1;
        end
        stall_prev = !dump_ready;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // driver tasks: inputs change 2 time units after the active edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_word(input logic [11:0] d, input logic last);
    int   cyc = 0;
    logic took = 1'b0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    while (!took && cyc < 20) begin
      @(negedge clk);
      took = ld_ready;
      step();
      cyc++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ld_accept", {31'h0, took}, 1);
    if (took && ld_ptr_m < DEPTH) begin
      model_mem[ld_ptr_m] = d;
      ld_ptr_m++;
    end
  endtask

  task automatic run_op(input logic [11:0] a, input logic we, input logic [16:0] d, input logic endp);
    ar_in = a; dm_en = we; wr_data = d; end_process = endp; rd_tag = 1'b1;
    last_rd_exp = model_read(a);
    exp_rd_q.push_back(last_rd_exp);
    if (we && int'(a) < DEPTH) model_mem[int'(a)] = d[11:0];
    if (endp) for (int i = 0; i < DUMP_LEN; i++) exp_dump_q.push_back({i == DUMP_LEN - 1, model_mem[i]});
    step();
    rd_tag = 1'b0; dm_en = 1'b0; end_process = 1'b0;
  endtask

  task automatic run_dump(input int target);
    int start = n_dump_hs;
    int cyc = 0;
    while ((n_dump_hs - start) < target && cyc < 200) begin
      dump_ready = ((cyc % 3) == 2);
      step();
      cyc++;
    end
    dump_ready = 1'b0;
    check("dump_count", 32'(n_dump_hs - start), 32'(target));
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_rd_q.delete();
    exp_dump_q.delete();
    ld_ptr_m = 0;
    repeat (3) step();
    mon_en = 1'b1;
    @(negedge clk);
    check("ld_ready_after_reset", {31'h0, ld_ready}, 1);
    check("state_after_reset", {30'h0, dbg_state}, {30'h0, 2'(ST_LOAD)});
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dm_out"}, {20'h0, dm_out}, 0);
    check({tag, "_proc_start"}, {31'h0, proc_start}, 0);
    check({tag, "_done"}, {31'h0, done}, 0);
    check({tag, "_dump_valid"}, {31'h0, dump_valid}, 0);
    check({tag, "_dump_last"}, {31'h0, dump_last}, 0);
    check({tag, "_dump_data"}, {20'h0, dump_data}, 0);
    check({tag, "_state"}, {30'h0, dbg_state}, {30'h0, 2'(ST_LOAD)});
  endtask

  initial begin
    logic [11:0] a;
    logic        we;

    // power-on reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    release_reset();

    // preload three words, last flagged on the third
    load_word(12'h00A, 1'b0);
    load_word(12'h00B, 1'b0);
    load_word(12'h00C, 1'b1);
    @(negedge clk);
    check("ld_ready_dropped", {31'h0, ld_ready}, 0);
    check("proc_start_on", {31'h0, proc_start}, 1);
    step();

    // directed reads / read-before-write, then fill the rest of memory
    run_op(12'd2, 1'b0, 17'h0, 1'b0);
    run_op(12'd2, 1'b1, 17'h1F123, 1'b0);
    run_op(12'd2, 1'b0, 17'h0, 1'b0);
    for (int i = 3; i < DEPTH; i++) run_op(12'(i), 1'b1, 17'($urandom), 1'b0);

    // out-of-range write is discarded and reads as zero
    run_op(12'd20, 1'b1, 17'h007FF, 1'b0);
    run_op(12'd20, 1'b0, 17'h0, 1'b0);
    run_op(12'd4, 1'b0, 17'h0, 1'b0);

    // randomized traffic; addresses 0..2 stay untouched so the dump holds known words
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = 12'($urandom_range(DEPTH, 4095));
      else a = 12'($urandom_range(0, DEPTH - 1));
      we = (int'(a) >= 3) && ($urandom_range(0, 1) == 1);
      run_op(a, we, 17'($urandom), 1'b0);
      if ($urandom_range(0, 4) == 0) step();
    end

    // end of program with a write on the same edge
    run_op(12'd5, 1'b1, 17'($urandom), 1'b1);
    @(negedge clk);
    check("run_exit_proc_start", {31'h0, proc_start}, 0);
    check("dump_first_fetch", {31'h0, dump_valid}, 0);
    check("dump_words_known", {model_mem[0], model_mem[1], model_mem[2][7:0]}, {12'h00A, 12'h00B, 8'h23});
    step();
    run_dump(DUMP_LEN);
    @(negedge clk);
    check("done_set", {31'h0, done}, 1);
    check("done_proc_start", {31'h0, proc_start}, 0);
    check("done_ld_ready", {31'h0, ld_ready}, 0);
    check("done_dump_valid", {31'h0, dump_valid}, 0);
    check("dm_out_held", {20'h0, dm_out}, {20'h0, last_rd_exp});
    check("dump_queue_empty", 32'(exp_dump_q.size()), 0);

    // DONE ignores load and write traffic and stays put
    step();
    ld_valid = 1'b1; ld_data = 12'hFFF; dm_en = 1'b1; ar_in = 12'd3; wr_data = 17'h00FFF;
    repeat (4) step();
    ld_valid = 1'b0; dm_en = 1'b0;
    @(negedge clk);
    check("done_sticky", {31'h0, done}, 1);

    // reset, reload only word 0, confirm the rest of memory survived
    rst_n = 1'b0;
    mon_en = 1'b0;
    release_reset();
    ar_in = 12'd1; dm_en = 1'b1; wr_data = 17'h00ABC;
    repeat (2) step();
    dm_en = 1'b0;
    load_word(12'h00A, 1'b1);
    @(negedge clk);
    check("reload_proc_start", {31'h0, proc_start}, 1);
    step();
    for (int i = 0; i < 8; i++) run_op(12'(i), 1'b0, 17'h0, 1'b0);
    run_op(12'd7, 1'b1, 17'($urandom), 1'b1);
    @(negedge clk);
    step();
    run_dump(1);
    step();
    @(negedge clk);
    check("dump_presenting", {31'h0, dump_valid}, 1);

    // abort mid-dump
    #1 mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    release_reset();
    load_word(12'h00A, 1'b1);
    step();
    for (int i = 0; i < 8; i++) run_op(12'(i), 1'b0, 17'h0, 1'b0);

    // preload without ld_last stops at the top of memory
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    release_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("full_load_not_running", {31'h0, proc_start}, 0);
      step();
      load_word(12'($urandom), 1'b0);
    end
    @(negedge clk);
    check("full_load_running", {31'h0, proc_start}, 1);
    step();
    for (int i = 0; i < 20; i++) run_op(12'($urandom_range(0, 20)), 1'b0, 17'h0, 1'b0);
    step();
    check("rd_queue_empty", 32'(exp_rd_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
